// File: rtl/qtime_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : qtime_dispatch
//  Brief    : Per-channel timed codeword queues; each head entry issues when
//             the timeline reaches its timestamp, or is dropped if already late.
//  Revision : 1.0 - initial release
// ============================================================================
module qtime_dispatch #(
    parameter int NCH        = 7,
    parameter int DEPTH      = 32,
    parameter int TIME_WIDTH = 20,
    parameter int CW_WIDTH   = 18
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [TIME_WIDTH-1:0]    t_cnt,
    input  logic [NCH-1:0]           wr_en,
    input  logic [TIME_WIDTH*NCH-1:0] wr_time,
    input  logic [CW_WIDTH*NCH-1:0]  wr_data,
    input  logic                     flush,
    output logic [NCH-1:0]           cw_valid,
    output logic [CW_WIDTH*NCH-1:0]  cw_data,
    output logic [NCH-1:0]           full,
    output logic [NCH-1:0]           empty,
    output logic [NCH-1:0]           overflow_err,
    output logic [NCH-1:0]           late_err
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = TIME_WIDTH + CW_WIDTH;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [c_ENT_W-1:0]    r_mem [DEPTH];
        logic [c_PTR_W-1:0]    r_wptr;
        logic [c_PTR_W-1:0]    r_rptr;
        logic [c_CNT_W-1:0]    r_count;
        logic                  r_valid;
        logic [CW_WIDTH-1:0]   r_data;
        logic                  r_ovf;
        logic                  r_late;

        logic [c_ENT_W-1:0]    w_head;
        logic [TIME_WIDTH-1:0] w_head_time;
        logic [CW_WIDTH-1:0]   w_head_cw;
        logic [TIME_WIDTH-1:0] w_d;
        logic                  w_nonempty;
        logic                  w_full;
        logic                  w_match;
        logic                  w_late;
        logic                  w_pop;
        logic                  w_push;
        logic                  w_drop;

        assign w_head      = r_mem[r_rptr];
        assign w_head_time = w_head[c_ENT_W-1 -: TIME_WIDTH];
        assign w_head_cw   = w_head[CW_WIDTH-1:0];
        // Modular distance: top bit set means the timestamp is in the past.
        assign w_d         = w_head_time - t_cnt;
        assign w_nonempty  = (r_count != '0);
        assign w_full      = (r_count == c_DEPTH);
        assign w_match     = w_nonempty && (w_d == '0);
        assign w_late      = w_nonempty && w_d[TIME_WIDTH-1];
        assign w_pop       = w_match || w_late;
        // A full queue still accepts a write when its head leaves this cycle.
        assign w_push      = wr_en[i] && !flush && (!w_full || w_pop);
        assign w_drop      = wr_en[i] && !flush && !w_push;

        // Storage carries no reset; occupancy alone decides what is valid.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wptr] <= {wr_time[i*TIME_WIDTH +: TIME_WIDTH],
                                  wr_data[i*CW_WIDTH +: CW_WIDTH]};
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
                r_valid <= 1'b0;
                r_data  <= '0;
                r_ovf   <= 1'b0;
                r_late  <= 1'b0;
            end else if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
                r_valid <= 1'b0;
                r_ovf   <= 1'b0;
                r_late  <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
                r_valid <= w_match;
                if (w_match) begin
                    r_data <= w_head_cw;
                end
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end
                if (w_late) begin
                    r_late <= 1'b1;
                end
            end
        end

        assign cw_valid[i]                      = r_valid;
        assign cw_data[i*CW_WIDTH +: CW_WIDTH]  = r_data;
        assign full[i]                          = w_full;
        assign empty[i]                         = !w_nonempty;
        assign overflow_err[i]                  = r_ovf;
        assign late_err[i]                      = r_late;
    end

endmodule
`default_nettype wire

// File: tb/tb_qtime_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qtime_dispatch
//  Brief    : Scoreboard bench for qtime_dispatch timed issue, late discard,
//             overflow, wrap, flush and reset behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qtime_dispatch;

    localparam int NCH   = 7;
    localparam int DEPTH = 32;
    localparam int TW    = 20;
    localparam int CW    = 18;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [TW-1:0]     t_cnt = '0;
    logic [NCH-1:0]    wr_en = '0;
    logic [TW*NCH-1:0] wr_time = '0;
    logic [CW*NCH-1:0] wr_data = '0;
    logic              flush = 1'b0;
    logic [NCH-1:0]    cw_valid;
    logic [CW*NCH-1:0] cw_data;
    logic [NCH-1:0]    full;
    logic [NCH-1:0]    empty;
    logic [NCH-1:0]    overflow_err;
    logic [NCH-1:0]    late_err;

    typedef struct {
        int            ch;
        logic [CW-1:0] data;
        logic [TW-1:0] t_exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    qtime_dispatch #(.NCH(NCH), .DEPTH(DEPTH), .TIME_WIDTH(TW), .CW_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .t_cnt(t_cnt), .wr_en(wr_en), .wr_time(wr_time),
        .wr_data(wr_data), .flush(flush), .cw_valid(cw_valid), .cw_data(cw_data),
        .full(full), .empty(empty), .overflow_err(overflow_err), .late_err(late_err)
    );

    always #5 clk = ~clk;

    // Every issue pulse must match the oldest pending expectation of its channel,
    // with the timeline one step past the scheduled time.
    always @(negedge clk) begin
        int idx;
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                if (cw_valid[i]) begin
                    idx = -1;
                    for (int k = 0; k < sb.size(); k++) begin
                        if (sb[k].ch == i) begin
                            idx = k;
                            break;
                        end
                    end
                    total++;
                    if (idx < 0) begin
                        bad++;
                        $display("FAIL unexpected_issue ch=%0d data=%h t_cnt=%h", i, cw_data[i*CW +: CW], t_cnt);
                    end else begin
                        if (cw_data[i*CW +: CW] !== sb[idx].data) begin
                            bad++;
                            $display("FAIL issue_data ch=%0d got=%h want=%h", i, cw_data[i*CW +: CW], sb[idx].data);
                        end
                        total++;
                        if (t_cnt !== sb[idx].t_exp) begin
                            bad++;
                            $display("FAIL issue_time ch=%0d got_t=%h want_t=%h", i, t_cnt, sb[idx].t_exp);
                        end
                        sb.delete(idx);
                    end
                end
            end
        end
    end

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            t_cnt = t_cnt + 1'b1;
        end
    endtask

    task automatic set_lane(input int ch, input logic [TW-1:0] tm, input logic [CW-1:0] d, input bit expect_issue);
        wr_en[ch]            = 1'b1;
        wr_time[ch*TW +: TW] = tm;
        wr_data[ch*CW +: CW] = d;
        if (expect_issue) sb.push_back('{ch: ch, data: d, t_exp: tm + 1'b1});
    endtask

    task automatic clear_lanes();
        wr_en = '0;
    endtask

    function automatic int pending(input int ch);
        int n = 0;
        foreach (sb[k]) if (sb[k].ch == ch) n++;
        return n;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        total++; if (cw_valid !== 7'h00) begin bad++; $display("FAIL reset_cw_valid got=%h want=%h", cw_valid, 7'h00); end
        total++; if (cw_data !== '0) begin bad++; $display("FAIL reset_cw_data got=%h want=0", cw_data); end
        total++; if (full !== 7'h00) begin bad++; $display("FAIL reset_full got=%h want=%h", full, 7'h00); end
        total++; if (empty !== 7'h7F) begin bad++; $display("FAIL reset_empty got=%h want=%h", empty, 7'h7F); end
        total++; if (overflow_err !== 7'h00) begin bad++; $display("FAIL reset_ovf got=%h want=%h", overflow_err, 7'h00); end
        total++; if (late_err !== 7'h00) begin bad++; $display("FAIL reset_late got=%h want=%h", late_err, 7'h00); end
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_basic_issue();
        t_cnt = 20'd10;
        set_lane(0, 20'd15, 18'h00005, 1'b1);
        step(1);
        clear_lanes();
        total++; if (empty[0] !== 1'b0) begin bad++; $display("FAIL basic_queued got=%b want=0", empty[0]); end
        step(10);
        total++; if (pending(0) != 0) begin bad++; $display("FAIL basic_pending got=%0d want=0", pending(0)); end
        total++; if (empty[0] !== 1'b1) begin bad++; $display("FAIL basic_empty got=%b want=1", empty[0]); end
        total++; if (cw_data[CW-1:0] !== 18'h00005) begin bad++; $display("FAIL basic_hold got=%h want=%h", cw_data[CW-1:0], 18'h00005); end
    endtask

    task automatic test_late();
        t_cnt = 20'd9;
        set_lane(2, 20'd5, 18'h2BEEF, 1'b0);
        step(1);
        clear_lanes();
        total++; if (late_err[2] !== 1'b0) begin bad++; $display("FAIL late_early got=%b want=0", late_err[2]); end
        step(1);
        total++; if (late_err[2] !== 1'b1) begin bad++; $display("FAIL late_flag got=%b want=1", late_err[2]); end
        total++; if (empty[2] !== 1'b1) begin bad++; $display("FAIL late_empty got=%b want=1", empty[2]); end
        step(3);
    endtask

    task automatic test_overflow();
        t_cnt = 20'd100;
        for (int k = 0; k < DEPTH; k++) begin
            set_lane(1, 20'(1000 + k), 18'(18'h01000 + k), 1'b1);
            step(1);
            clear_lanes();
        end
        total++; if (full[1] !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b want=1", full[1]); end
        total++; if (overflow_err[1] !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", overflow_err[1]); end
        set_lane(1, 20'd1100, 18'h3DEAD, 1'b0);
        step(1);
        clear_lanes();
        total++; if (overflow_err[1] !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow_err[1]); end
        total++; if (full[1] !== 1'b1) begin bad++; $display("FAIL ovf_still_full got=%b want=1", full[1]); end
        t_cnt = 20'd990;
        step(50);
        total++; if (pending(1) != 0) begin bad++; $display("FAIL ovf_pending got=%0d want=0", pending(1)); end
        total++; if (empty[1] !== 1'b1) begin bad++; $display("FAIL ovf_empty got=%b want=1", empty[1]); end
    endtask

    task automatic test_wrap();
        t_cnt = 20'hFFFFE;
        set_lane(4, 20'h00001, 18'h3ABCD, 1'b1);
        step(1);
        clear_lanes();
        step(6);
        total++; if (pending(4) != 0) begin bad++; $display("FAIL wrap_pending got=%0d want=0", pending(4)); end
        total++; if (late_err[4] !== 1'b0) begin bad++; $display("FAIL wrap_late got=%b want=0", late_err[4]); end
    endtask

    task automatic test_same_time();
        t_cnt = 20'd30;
        set_lane(1, 20'd40, 18'h00011, 1'b1);
        set_lane(4, 20'd40, 18'h00044, 1'b1);
        set_lane(5, 20'd50, 18'h00055, 1'b1);
        step(1);
        clear_lanes();
        set_lane(5, 20'd50, 18'h00056, 1'b0);
        step(1);
        clear_lanes();
        step(25);
        total++; if (pending(1) + pending(4) + pending(5) != 0) begin bad++; $display("FAIL same_pending got=%0d want=0", pending(1) + pending(4) + pending(5)); end
        total++; if (late_err[5] !== 1'b1) begin bad++; $display("FAIL same_late5 got=%b want=1", late_err[5]); end
        total++; if (late_err[4] !== 1'b0) begin bad++; $display("FAIL same_late4 got=%b want=0", late_err[4]); end
        total++; if (empty[5] !== 1'b1) begin bad++; $display("FAIL same_empty5 got=%b want=1", empty[5]); end
    endtask

    task automatic test_back_to_back();
        logic [TW-1:0] base;
        t_cnt = 20'd2000;
        base  = 20'd2040;
        for (int k = 0; k < DEPTH; k++) begin
            set_lane(6, base + 20'(k), 18'(18'h00100 + k), 1'b1);
            step(1);
            clear_lanes();
        end
        total++; if (full[6] !== 1'b1) begin bad++; $display("FAIL b2b_full got=%b want=1", full[6]); end
        for (int k = 0; k < 16 && t_cnt != base; k++) step(1);
        // Head leaves on this edge, so the write into a full queue is accepted.
        set_lane(6, base + 20'd32, 18'h00120, 1'b1);
        step(1);
        clear_lanes();
        total++; if (overflow_err[6] !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%b want=0", overflow_err[6]); end
        total++; if (full[6] !== 1'b1) begin bad++; $display("FAIL b2b_refull got=%b want=1", full[6]); end
        step(40);
        total++; if (pending(6) != 0) begin bad++; $display("FAIL b2b_pending got=%0d want=0", pending(6)); end
        total++; if (empty[6] !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b want=1", empty[6]); end
    endtask

    task automatic test_flush();
        t_cnt = 20'd3000;
        set_lane(0, 20'd3100, 18'h00AAA, 1'b0);
        set_lane(3, 20'd3100, 18'h00BBB, 1'b0);
        step(1);
        clear_lanes();
        total++; if (empty[3] !== 1'b0) begin bad++; $display("FAIL flush_pre got=%b want=0", empty[3]); end
        flush = 1'b1;
        set_lane(3, 20'd3050, 18'h00CCC, 1'b0);
        step(1);
        clear_lanes();
        flush = 1'b0;
        total++; if (empty !== 7'h7F) begin bad++; $display("FAIL flush_empty got=%h want=%h", empty, 7'h7F); end
        total++; if (overflow_err !== 7'h00) begin bad++; $display("FAIL flush_ovf got=%h want=%h", overflow_err, 7'h00); end
        total++; if (late_err !== 7'h00) begin bad++; $display("FAIL flush_late got=%h want=%h", late_err, 7'h00); end
        total++; if (cw_valid !== 7'h00) begin bad++; $display("FAIL flush_valid got=%h want=%h", cw_valid, 7'h00); end
        step(120);
        total++; if (empty !== 7'h7F) begin bad++; $display("FAIL flush_after got=%h want=%h", empty, 7'h7F); end
    endtask

    task automatic test_reset_mid();
        t_cnt = 20'd4000;
        set_lane(2, 20'd4005, 18'h01234, 1'b0);
        step(1);
        clear_lanes();
        reset = 1'b1;
        #1;
        total++; if (empty[2] !== 1'b1) begin bad++; $display("FAIL rstmid_async got=%b want=1", empty[2]); end
        step(2);
        reset = 1'b0;
        step(12);
        total++; if (empty !== 7'h7F) begin bad++; $display("FAIL rstmid_empty got=%h want=%h", empty, 7'h7F); end
        total++; if (cw_data !== '0) begin bad++; $display("FAIL rstmid_data got=%h want=0", cw_data); end
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_late();
        test_overflow();
        test_wrap();
        test_same_time();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover_expectations got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
